instr_sequencer: RTL

// - Multi-cycle FSM that steps the 16-bit core through FETCH/DECODE/EXEC/MEM/WB/DISP.
// - Consumes the decoder strobes (mem_read_en, mem_write_en, reg_write_en, display) and re-issues them as timed, handshaked strobes.
// - Sits between the Control_unit decoder, instruction/data memory, the register file and the display port.

---
 rtl/cpu_seq_pkg.sv | 9 +
 rtl/seq_timeout_counter.sv | 18 +
 rtl/instr_sequencer.sv | 86 ++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding and instruction constants for the instruction sequencer
package cpu_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, DISP, FAULT} state_t;
  localparam logic [1:0] INSTR_TYPE_ALU  = 2'b00;
  localparam logic [1:0] INSTR_TYPE_MEM  = 2'b01;
  localparam logic [1:0] INSTR_TYPE_CTRL = 2'b10;
  localparam logic [1:0] INSTR_TYPE_IO   = 2'b11;
  localparam logic [4:0] HALT_OPCODE     = 5'h1F;
endpackage

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter: counts consecutive wait cycles and flags the last one allowed before timing out
module seq_timeout_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign expired = enable && cnt == limit - 1'b1;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB/DISP control FSM with handshaked strobes
module instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [4:0] HALT_OPCODE = cpu_seq_pkg::HALT_OPCODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        instr_valid,
  input  logic [1:0]  instr_type,
  input  logic [4:0]  opcode,
  input  logic        dec_mem_rd,
  input  logic        dec_mem_wr,
  input  logic        dec_reg_wr,
  input  logic        dec_disp,
  input  logic        mem_ready,
  input  logic        disp_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        rf_we,
  output logic        disp_valid,
  output logic        pc_en,
  output logic        busy,
  output logic        fault,
  output logic [15:0] retired
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  state_t state, nxt, post, after;
  logic rd, wr, rw, dp, waiting, expired, retire, halt_dec;
  // counter runs only while stalled on a handshake; any other cycle resets it
  assign waiting = (state == MEM && !mem_ready) || (state == DISP && !disp_ready);
  seq_timeout_counter #(.W(W)) u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .clear(!waiting),
    .enable(waiting),
    .limit(W'(MEM_TIMEOUT)),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {rd, wr, rw, dp} <= '0;
      retired <= '0;
    end else begin
      if (state == DECODE) {rd, wr, rw, dp} <= {dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_disp};
      if (retire || halt_dec) retired <= retired + 1'b1;
    end
  assign after = halt_req ? IDLE : FETCH;
  assign post  = dp ? DISP : rw ? WB : after;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = instr_valid ? DECODE : FETCH;
      DECODE:  nxt = instr_type != INSTR_TYPE_CTRL ? EXEC : opcode == HALT_OPCODE ? IDLE : FAULT;
      EXEC:    nxt = rd || wr ? MEM : post;
      MEM:     nxt = rd && wr ? FAULT : mem_ready ? post : expired ? FAULT : MEM;
      WB:      nxt = after;
      DISP:    nxt = disp_ready ? after : expired ? FAULT : DISP;
      default: nxt = FAULT;
    endcase
  end
  always_comb begin
    imem_req   = state == FETCH;
    ir_load    = state == FETCH && instr_valid;
    dmem_rd    = state == MEM && rd && !wr;
    dmem_wr    = state == MEM && wr && !rd;
    rf_we      = state == WB;
    disp_valid = state == DISP;
    retire     = (state == EXEC && !(rd || wr || dp || rw)) ||
                 (state == MEM && mem_ready && !(rd && wr) && !dp && !rw) ||
                 state == WB || (state == DISP && disp_ready);
    halt_dec   = state == DECODE && instr_type == INSTR_TYPE_CTRL && opcode == HALT_OPCODE;
    pc_en      = retire;
    busy       = state != IDLE && state != FAULT;
    fault      = state == FAULT;
  end
endmodule
